// File: rtl/axis_id_rr_arbiter_if.sv
// Bus bundle for the packet round-robin arbiter: NUM_PORTS packed source
// streams in, one tid-stamped stream out. slave = arbiter side, master = environment side.
interface axis_id_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TID_WIDTH  = 2
);
  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_axis_tdata;
  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]                s_axis_tlast;
  logic [NUM_PORTS-1:0]                s_axis_tvalid;
  logic [NUM_PORTS-1:0]                s_axis_tready;
  logic [DATA_WIDTH-1:0]               m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic [TID_WIDTH-1:0]                m_axis_tid;
  logic                                m_axis_tlast;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axis_id_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream sources; grant is held
// until tlast is accepted and every output beat carries its source index on tid.
module axis_id_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TID_WIDTH  = 2
) (
  input logic                 aclk,
  input logic                 aresetn,
  axis_id_rr_arbiter_if.slave bus
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KW-1:0]         tkeep;
    logic                  tlast;
  } beat_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                       r_state, w_state_nxt;
  logic [PW-1:0]                r_grant, r_ptr, w_win, w_idx;
  logic                         w_win_vld, w_busy, w_out_rdy, w_any_hs;
  logic [NUM_PORTS-1:0]         w_tready, w_hs;
  beat_t [NUM_PORTS-1:0]        w_beat_sel;
  beat_t                        w_beat, r_beat;
  logic                         r_vld;
  logic [TID_WIDTH-1:0]         r_tid;

  // Scan downward so the request closest above the pointer is assigned last and wins.
  always_comb begin
    w_win     = r_ptr;
    w_win_vld = 1'b0;
    w_idx     = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_PORTS);
      if (bus.s_axis_tvalid[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_vld) w_state_nxt = BUSY;
      BUSY:    if (w_any_hs && w_beat.tlast) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A stalled output register blocks every source.
  always_comb begin
    w_busy    = (r_state == BUSY);
    w_out_rdy = w_busy && (!r_vld || bus.m_axis_tready);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (r_state == IDLE && w_win_vld) begin
      r_grant <= w_win;
      r_ptr   <= (w_win == PW'(NUM_PORTS-1)) ? '0 : w_win + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    beat_t w_lane;
    assign w_lane.tdata  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_lane.tkeep  = bus.s_axis_tkeep[i*KW +: KW];
    assign w_lane.tlast  = bus.s_axis_tlast[i];
    assign w_tready[i]   = w_out_rdy && (r_grant == PW'(i));
    assign w_hs[i]       = w_tready[i] && bus.s_axis_tvalid[i];
    assign w_beat_sel[i] = (r_grant == PW'(i)) ? w_lane : '0;
  end

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_beat = w_beat | w_beat_sel[i];
  end

  assign w_any_hs = |w_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_vld  <= 1'b0;
      r_beat <= '0;
      r_tid  <= '0;
    end else if (w_any_hs) begin
      r_vld  <= 1'b1;
      r_beat <= w_beat;
      r_tid  <= TID_WIDTH'(r_grant);
    end else if (bus.m_axis_tready) begin
      r_vld  <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.m_axis_tvalid = r_vld;
  assign bus.m_axis_tdata  = r_beat.tdata;
  assign bus.m_axis_tkeep  = r_beat.tkeep;
  assign bus.m_axis_tlast  = r_beat.tlast;
  assign bus.m_axis_tid    = r_tid;
endmodule

// File: tb/tb_axis_id_rr_arbiter.sv
// Directed + randomized bench for axis_id_rr_arbiter with a packet-level round-robin model.
module tb_axis_id_rr_arbiter;
  localparam int NP = 4, DW = 8, KW = 1, TW = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_id_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TID_WIDTH(TW)) bus ();
  axis_id_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TID_WIDTH(TW)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [TW-1:0] tid;
  } obs_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    bit            first;
  } src_t;

  src_t src_q [NP][$];
  obs_t obs_q[$], exp_q[$];
  int   obs_cyc[$];
  int   checks = 0, passes = 0, cyc = 0, m_ptr = 0, rdy_mode = 0;
  bit   bubbles = 0, prev_stall = 0;
  logic [31:0] prev_out;
  logic [NP-1:0] s_rdy_smp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic l, input bit f);
    src_t b;
    b.data = d; b.keep = k; b.last = l; b.first = f;
    src_q[p].push_back(b);
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int j = 0; j < len; j++)
      add_beat(p, DW'($urandom), KW'($urandom_range(1)), j == len-1, j == 0);
  endtask

  task automatic redrive();
    logic [NP*DW-1:0] d;
    logic [NP*KW-1:0] k;
    logic [NP-1:0]    l, v;
    d = '0; k = '0; l = '0; v = '0;
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        d[i*DW +: DW] = src_q[i][0].data;
        k[i*KW +: KW] = src_q[i][0].keep;
        l[i]          = src_q[i][0].last;
        v[i]          = !(bubbles && !src_q[i][0].first && $urandom_range(3) == 0);
      end
    end
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = v;
    bus.m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample/check at negedge, retire accepted source beats after posedge.
  task automatic cycle();
    logic [31:0]   cur;
    logic [NP-1:0] shs;
    bit            stall;
    obs_t          o;
    @(negedge aclk);
    cyc++;
    cur = 32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tid, bus.m_axis_tlast});
    if (prev_stall) chk("hold_stable", cur, prev_out);
    stall = bus.m_axis_tvalid && !bus.m_axis_tready;
    if (stall) chk("stall_sready", bus.s_axis_tready, 0);
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      o.data = bus.m_axis_tdata; o.keep = bus.m_axis_tkeep;
      o.last = bus.m_axis_tlast; o.tid  = bus.m_axis_tid;
      obs_q.push_back(o);
      obs_cyc.push_back(cyc);
    end
    s_rdy_smp  = bus.s_axis_tready;
    shs        = bus.s_axis_tvalid & bus.s_axis_tready;
    prev_stall = stall;
    prev_out   = cur;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NP; i++) if (shs[i]) void'(src_q[i].pop_front());
    redrive();
  endtask

  // Reference: whole packets granted in round-robin order from the model pointer.
  task automatic build_exp();
    src_t q [NP][$];
    src_t b;
    obs_t e;
    int   ptr, w;
    bit   any;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    for (int i = 0; i < NP; i++) q[i] = src_q[i];
    ptr = m_ptr;
    while (1) begin
      any = 0; w = 0;
      for (int k = 0; k < NP; k++)
        if (!any && q[(ptr + k) % NP].size() > 0) begin w = (ptr + k) % NP; any = 1; end
      if (!any) break;
      do begin
        b = q[w].pop_front();
        e.data = b.data; e.keep = b.keep; e.last = b.last; e.tid = TW'(w);
        exp_q.push_back(e);
      end while (!b.last && q[w].size() > 0);
      ptr = (w + 1) % NP;
    end
    m_ptr = ptr;
    redrive();
  endtask

  task automatic finish_run(input string tag, input int max);
    int n = 0;
    while ((pending() || bus.m_axis_tvalid === 1'b1) && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 64'(n < max), 1);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      chk({tag, "_beat"}, obs_q[k], exp_q[k]);
  endtask

  task automatic wait_obs(input string tag, input int want, input int max);
    int n = 0;
    while (obs_q.size() < want && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_seen"}, 64'(obs_q.size() >= want), 1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    prev_stall = 0; m_ptr = 0; rdy_mode = 0; bubbles = 0;
    redrive();
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin : main
    int c0;
    redrive();
    #1;
    chk("rst_out", 64'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tid, bus.m_axis_tlast}), 0);
    chk("rst_sready", bus.s_axis_tready, 0);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
    cycle(); cycle();
    chk("idle_mvalid", bus.m_axis_tvalid, 0);
    chk("idle_sready", s_rdy_smp, 0);

    // Port 2, 3 beats: latency 2, back-to-back beats.
    add_beat(2, 8'h11, 1'b1, 1'b0, 1'b1);
    add_beat(2, 8'h22, 1'b1, 1'b0, 1'b0);
    add_beat(2, 8'h33, 1'b1, 1'b1, 1'b0);
    build_exp();
    c0 = cyc + 1;
    finish_run("p2_3beat", 40);
    if (obs_q.size() == 3) begin
      chk("p2_latency", obs_cyc[0] - c0, 2);
      chk("p2_b2_cyc", obs_cyc[1] - obs_cyc[0], 1);
      chk("p2_b3_cyc", obs_cyc[2] - obs_cyc[1], 1);
    end

    // All ports busy from reset: 0,0,1,1,2,2,3,3,0,0 with one idle cycle per packet.
    do_reset();
    for (int i = 0; i < NP; i++) add_pkt(i, 2);
    add_pkt(0, 2);
    build_exp();
    finish_run("all_rr", 100);
    if (obs_q.size() == 10) begin
      for (int k = 0; k < 10; k++) chk("all_rr_tid", obs_q[k].tid, (k / 2) % NP);
      for (int k = 1; k < 10; k++) chk("all_rr_gap", obs_cyc[k] - obs_cyc[k-1], (k % 2 == 0) ? 2 : 1);
    end

    // Port 1 stalled downstream for 5 cycles mid-packet.
    add_pkt(1, 4);
    build_exp();
    wait_obs("stall", 1, 20);
    rdy_mode = 2;
    redrive();
    repeat (5) cycle();
    chk("stall_held_valid", bus.m_axis_tvalid, 1);
    rdy_mode = 0;
    redrive();
    finish_run("stall", 40);

    // Pointer wrap: port 3, then 0 and 3 together.
    add_pkt(3, 1);
    build_exp();
    finish_run("wrap_a", 20);
    add_pkt(0, 2);
    add_pkt(3, 2);
    build_exp();
    finish_run("wrap_b", 40);
    if (obs_q.size() == 4) begin
      chk("wrap_first", obs_q[0].tid, 0);
      chk("wrap_second", obs_q[2].tid, 3);
    end

    // Asynchronous reset mid port-0 packet.
    add_pkt(0, 4);
    build_exp();
    wait_obs("midrst", 1, 20);
    aresetn = 1'b0;
    #1;
    chk("midrst_mvalid", bus.m_axis_tvalid, 0);
    chk("midrst_sready", bus.s_axis_tready, 0);
    do_reset();
    add_pkt(1, 2);
    build_exp();
    finish_run("post_rst", 30);
    if (obs_q.size() > 0) chk("post_rst_tid", obs_q[0].tid, 1);

    // Single-beat packet on port 2, followed by another port-2 packet.
    add_beat(2, 8'h5A, 1'b1, 1'b1, 1'b1);
    add_pkt(2, 2);
    build_exp();
    wait_obs("single", 1, 20);
    chk("single_idle_sready", s_rdy_smp, 0);
    chk("single_beat", obs_q[0], {8'h5A, 1'b1, 1'b1, 2'd2});
    finish_run("single", 30);

    // Random packets, mid-packet source bubbles, random downstream backpressure.
    bubbles  = 1;
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NP; i++)
        for (int p = $urandom_range(3); p > 0; p--) add_pkt(i, $urandom_range(1, 4));
      build_exp();
      finish_run("rand", 800);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/axis_id_rr_arbiter.md
Name: axis_id_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream sources onto one AXI-Stream output.
- Each output beat is stamped with the winning port index on m_axis_tid.
- The output feeds the TID/TKEEP-to-TUSER packer stage, so multiple MAC/tester streams share one downstream datapath.
- Grant is held for a whole packet, from grant until the tlast beat is accepted, so packets are never interleaved.

Parameters:
- NUM_PORTS, 4, number of input streams; must satisfy 2 <= NUM_PORTS <= 2**TID_WIDTH.
- DATA_WIDTH, 8, tdata width in bits; must be a multiple of 8.
- TID_WIDTH, 2, width of m_axis_tid.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, packed the same way.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  DATA_WIDTH/8  merged byte enables.
- m_axis_tid  out  TID_WIDTH  index of the source port of the current beat.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Clock and reset are fixed: one clock, aclk; aresetn is asynchronous, active-low.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - State = IDLE, grant register = 0, priority pointer = 0.
  - m_axis_tvalid = 0; m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast = 0.
  - s_axis_tready = all 0.
- Reset mid-packet:
  - The in-flight beat held in the output register is dropped.
  - The partial packet is not completed; after reset, arbitration restarts from port 0.
- FSM, IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid[i] = 1, the winner is the first set bit scanning from the pointer upward modulo NUM_PORTS.
  - On a win: grant <= winner, pointer <= (winner+1) mod NUM_PORTS (wraps NUM_PORTS-1 -> 0), go to BUSY.
  - With no requests: stay in IDLE, pointer unchanged.
- FSM, BUSY:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready); all other readies = 0.
  - On a source handshake on port grant, load the output register with that port's tdata, tkeep and tlast, tid = grant, and m_axis_tvalid <= 1.
  - If the accepted beat has tlast = 1, go to IDLE.
- Output register:
  - Single-stage pipeline; latency from source handshake to m_axis_tvalid is 1 cycle.
  - If m_axis_tready = 1 with no new load, m_axis_tvalid <= 0.
  - Load and drain in the same cycle sustain full throughput: 1 beat per cycle within a packet.
  - While m_axis_tvalid = 1 and m_axis_tready = 0, all output signals are held stable (AXI-S rule), and no source is readied.
- Arbitration is not re-evaluated while in BUSY; a source dropping tvalid mid-packet stalls the merge without releasing the grant.
- Packet gap: one cycle spent in IDLE between consecutive packets (arbitration cycle).
- A single-beat packet (tlast on the first beat) is legal: BUSY lasts exactly one handshake.
- tid width rule: grant is zero-extended to TID_WIDTH.

Test Plan:
- Reset, then port 2 sends a 3-beat packet (tdata 0x11/0x22/0x33, tlast on beat 3), tready=1:
  - m_axis shows 0x11, 0x22, 0x33 on consecutive cycles with tid=2 and tlast only on 0x33.
  - First output beat appears 2 cycles after tvalid rises: arbitration plus register.
- Ports 0..3 all continuously offer 2-beat packets:
  - Output tid sequence is 0,0,1,1,2,2,3,3,0,0.
  - Exactly one idle cycle between packets.
- Grant port 1, hold m_axis_tready=0 for 5 cycles mid-packet:
  - m_axis_tdata/tid/tlast/tkeep stay constant.
  - s_axis_tready = 0000 throughout.
  - No beat is lost or duplicated after tready returns to 1.
- Port 3 granted, then ports 0 and 3 request together:
  - The pointer wraps to 0, so port 0 wins next.
  - Port 3 wins the following arbitration.
- Assert aresetn=0 in the middle of a port-0 packet:
  - m_axis_tvalid and all s_axis_tready go to 0 immediately, without waiting for a clock edge.
  - After release, a port-1-only request is granted with tid=1.
- Port 2 sends a single-beat packet with tkeep=1 and tlast=1:
  - One output beat with tid=2, tlast=1, tkeep=1.
  - FSM returns to IDLE the next cycle.
